// File: rtl/cpu_pkg.sv
// cpu_pkg: datapath constants and routing state type shared with demux8_route.
package cpu_pkg;
    localparam int DATA_W = 8;
    typedef enum logic {ST_EMPTY, ST_FULL} route_state_t;
endpackage

// File: rtl/demux8_route_demux2.sv
// demux2: 1-bit 1-to-2 combinational steer; the unselected output drives 0.
module demux2 (
    input  logic d,
    input  logic sel,
    output logic y0,
    output logic y1
);
    assign y0 = sel ? 1'b0 : d;
    assign y1 = sel ? d : 1'b0;
endmodule

// File: rtl/demux8_route.sv
// demux8_route: registered 1-to-N byte demux with valid/ready on every port.
// Define DEMUX8_ROUTE_BROADCAST_EN to add the in_bcast all-lanes delivery mode.
module demux8_route
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int N_OUT = 2,
    localparam int SEL_W = $clog2(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
`ifdef DEMUX8_ROUTE_BROADCAST_EN
    input  logic                   in_bcast,
`endif
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic                   err_drop
);
    localparam int LEAVES = 1 << SEL_W;
    route_state_t state_q, state_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic [SEL_W-1:0] hold_sel_q, hold_sel_d;
    logic err_drop_q, err_drop_d;
    logic [N_OUT-1:0] pending, pend_left;
    logic full, bcast, accept, bad_sel;
    logic [WIDTH-1:0] root;
    logic [LEAVES*WIDTH-1:0] leaves;
`ifdef DEMUX8_ROUTE_BROADCAST_EN
    logic bcast_q, bcast_d;
    logic [N_OUT-1:0] pend_q, pend_d, in_onehot;
    assign bcast = in_bcast;
    assign in_onehot = N_OUT'(1) << in_sel;
    assign pending = full ? pend_q : '0;
`else
    assign bcast = 1'b0;
    assign pending = full ? (N_OUT'(1) << hold_sel_q) : '0;
`endif
    assign full = (state_q == ST_FULL);
    // lanes still owed the held byte after this cycle's readies
    assign pend_left = pending & ~out_ready;
    assign in_ready = !full || (pend_left == '0);
    assign accept = in_valid && in_ready;
    assign bad_sel = accept && !bcast && ({1'b0, in_sel} >= (SEL_W+1)'(N_OUT));
    assign out_valid = pending;
    assign err_drop = err_drop_q;
    assign root = full ? hold_data_q : '0;
    always_comb begin
        state_d = state_q;
        hold_data_d = hold_data_q;
        hold_sel_d = hold_sel_q;
        err_drop_d = bad_sel;
`ifdef DEMUX8_ROUTE_BROADCAST_EN
        bcast_d = bcast_q;
        pend_d = pend_left;
`endif
        if (accept && !bad_sel) begin
            state_d = ST_FULL;
            hold_data_d = in_data;
            hold_sel_d = in_sel;
`ifdef DEMUX8_ROUTE_BROADCAST_EN
            bcast_d = bcast;
            pend_d = bcast ? '1 : in_onehot;
`endif
        end else if (pend_left == '0) begin
            state_d = ST_EMPTY;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            hold_data_q <= '0;
            hold_sel_q <= '0;
            err_drop_q <= 1'b0;
`ifdef DEMUX8_ROUTE_BROADCAST_EN
            bcast_q <= 1'b0;
            pend_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            hold_data_q <= hold_data_d;
            hold_sel_q <= hold_sel_d;
            err_drop_q <= err_drop_d;
`ifdef DEMUX8_ROUTE_BROADCAST_EN
            bcast_q <= bcast_d;
            pend_q <= pend_d;
`endif
        end
    end
    // binary steer tree: level l splits on select bit SEL_W-l, MSB first
    for (genvar l = 0; l <= SEL_W; l++) begin : g_lvl
        logic [(1<<l)*WIDTH-1:0] v;
        if (l == 0) begin : g_root
            assign v = root;
        end else begin : g_split
            for (genvar n = 0; n < (1 << (l-1)); n++) begin : g_node
                for (genvar b = 0; b < WIDTH; b++) begin : g_bit
                    demux2 u_demux2 (
                        .d  (g_lvl[l-1].v[n*WIDTH+b]),
                        .sel(hold_sel_q[SEL_W-l]),
                        .y0 (v[2*n*WIDTH+b]),
                        .y1 (v[(2*n+1)*WIDTH+b])
                    );
                end
            end
        end
    end
    assign leaves = g_lvl[SEL_W].v;
`ifdef DEMUX8_ROUTE_BROADCAST_EN
    always_comb begin
        out_data = '0;
        for (int k = 0; k < N_OUT; k++)
            out_data[k*WIDTH +: WIDTH] = bcast_q ? root : leaves[k*WIDTH +: WIDTH];
    end
`else
    assign out_data = leaves[N_OUT*WIDTH-1:0];
`endif
endmodule

// File: tb/tb_demux8_route.sv
// tb_demux8_route: directed checks of routing, backpressure, reset and select drops.
module tb_demux8_route;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] in_data = '0, in_data3 = '0;
    logic in_sel = 1'b0;
    logic [1:0] in_sel3 = '0;
    logic in_valid = 1'b0, in_valid3 = 1'b0;
    logic in_ready, in_ready3;
    logic [15:0] out_data;
    logic [23:0] out_data3;
    logic [1:0] out_valid, out_ready = '0;
    logic [2:0] out_valid3, out_ready3 = '0;
    logic err_drop, err_drop3;
`ifdef DEMUX8_ROUTE_BROADCAST_EN
    logic in_bcast = 1'b0, in_bcast3 = 1'b0;
`endif
    int n_chk = 0;
    int n_bad = 0;
    int sels [3] = '{0, 1, 0};

    always #5 clk = ~clk;

    demux8_route #(.WIDTH(8), .N_OUT(2)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
`ifdef DEMUX8_ROUTE_BROADCAST_EN
        .in_bcast(in_bcast),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .err_drop(err_drop)
    );

    demux8_route #(.WIDTH(8), .N_OUT(3)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_sel(in_sel3),
`ifdef DEMUX8_ROUTE_BROADCAST_EN
        .in_bcast(in_bcast3),
`endif
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .err_drop(err_drop3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lane(input int s, input logic [7:0] d);
        return 32'(d) << (8 * s);
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_err", 32'(err_drop), 0);
        check("rst_valid3", 32'(out_valid3), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 1);
        // single byte to lane 1
        in_data = 8'hA5; in_sel = 1'b1; in_valid = 1'b1; out_ready = 2'b11;
        #1 check("a5_ready", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("a5_valid", 32'(out_valid), 32'h2);
        check("a5_data", 32'(out_data), 32'hA500);
        @(negedge clk);
        check("a5_gone_valid", 32'(out_valid), 0);
        check("a5_gone_data", 32'(out_data), 0);
        // back-to-back stream
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                check("b2b_valid", 32'(out_valid), 32'(1) << sels[i-1]);
                check("b2b_data", 32'(out_data), lane(sels[i-1], 8'(i)));
            end
            if (i < 3) begin
                in_data = 8'(i + 1); in_sel = 1'(sels[i]); in_valid = 1'b1;
                #1 check("b2b_ready", 32'(in_ready), 1);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_idle", 32'(out_valid), 0);
        // stall on lane 0, then drain and refill in the same cycle
        out_ready = 2'b00; in_data = 8'h3C; in_sel = 1'b0; in_valid = 1'b1;
        #1 check("stall_accept_ready", 32'(in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_data = 8'h7E; in_sel = 1'b1; in_valid = 1'b1;
            #1;
            check("stall_valid", 32'(out_valid), 32'h1);
            check("stall_data", 32'(out_data), 32'h003C);
            check("stall_ready", 32'(in_ready), 0);
        end
        @(negedge clk);
        out_ready = 2'b11;
        #1;
        check("release_ready", 32'(in_ready), 1);
        check("release_data", 32'(out_data), 32'h003C);
        @(negedge clk);
        in_valid = 1'b0;
        check("refill_valid", 32'(out_valid), 32'h2);
        check("refill_data", 32'(out_data), 32'h7E00);
        @(negedge clk);
        check("refill_idle", 32'(out_valid), 0);
        // reset while a byte is stalled
        out_ready = 2'b00; in_data = 8'h55; in_sel = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("pre_rst_valid", 32'(out_valid), 32'h1);
        check("pre_rst_ready", 32'(in_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_data", 32'(out_data), 0);
        check("mid_rst_ready", 32'(in_ready), 1);
        out_ready = 2'b11;
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_never", 32'(out_valid), 0);
        end
        check("no_err_two_lane", 32'(err_drop), 0);
        // three-lane instance: lane 2 delivery, then drop while draining, then drop while empty
        out_ready3 = 3'b111; in_data3 = 8'hC3; in_sel3 = 2'd2; in_valid3 = 1'b1;
        #1 check("l2_ready", 32'(in_ready3), 1);
        @(negedge clk);
        in_data3 = 8'h5A; in_sel3 = 2'd3;
        #1;
        check("l2_valid", 32'(out_valid3), 32'h4);
        check("l2_data", 32'(out_data3), 32'hC30000);
        check("bad_ready_full", 32'(in_ready3), 1);
        @(negedge clk);
        in_valid3 = 1'b0;
        check("bad_err_pulse", 32'(err_drop3), 1);
        check("bad_valid", 32'(out_valid3), 0);
        check("bad_data", 32'(out_data3), 0);
        @(negedge clk);
        check("bad_err_clear", 32'(err_drop3), 0);
        in_sel3 = 2'd3; in_valid3 = 1'b1;
        #1 check("bad_ready_empty", 32'(in_ready3), 1);
        @(negedge clk);
        in_valid3 = 1'b0;
        check("bad2_err_pulse", 32'(err_drop3), 1);
        check("bad2_valid", 32'(out_valid3), 0);
        @(negedge clk);
        check("bad2_err_clear", 32'(err_drop3), 0);
`ifdef DEMUX8_ROUTE_BROADCAST_EN
        // broadcast: lane 0 takes it at cycle 1, lane 1 at cycle 3
        out_ready = 2'b00; in_data = 8'h99; in_bcast = 1'b1; in_valid = 1'b1;
        #1 check("bc_accept_ready", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0; in_bcast = 1'b0; out_ready = 2'b01;
        #1;
        check("bc_c1_valid", 32'(out_valid), 32'h3);
        check("bc_c1_data", 32'(out_data), 32'h9999);
        check("bc_c1_ready", 32'(in_ready), 0);
        @(negedge clk);
        out_ready = 2'b00;
        #1;
        check("bc_c2_valid", 32'(out_valid), 32'h2);
        check("bc_c2_data", 32'(out_data), 32'h9999);
        check("bc_c2_ready", 32'(in_ready), 0);
        @(negedge clk);
        out_ready = 2'b10;
        #1;
        check("bc_c3_valid", 32'(out_valid), 32'h2);
        check("bc_c3_ready", 32'(in_ready), 1);
        @(negedge clk);
        check("bc_done_valid", 32'(out_valid), 0);
        check("bc_done_data", 32'(out_data), 0);
`endif
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/demux8_route.md
# demux8_route

Registered 8-bit 1-to-N demultiplexer with valid/ready handshakes on every port. It takes one datapath byte plus a destination select and delivers it to exactly one of N consumers, such as register-file write ports or output latches. It is the steering counterpart of the 8-bit 2:1 operand select mux in the datapath. It adds one pipeline register and full backpressure so that a stalled consumer never loses data.

## Interface
- `WIDTH`, 8, data width per lane.
- `N_OUT`, 2, number of destinations (2..8).
- `SEL_W`, `$clog2(N_OUT)`, select width (derived, not overridden).
- `clk` input 1: the only clock. All state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input WIDTH: byte to route.
- `in_sel` input SEL_W: destination index.
- `in_valid` input 1: producer offers `in_data`/`in_sel`.
- `in_ready` output 1: block accepts the offer this cycle.
- `out_data` output N_OUT*WIDTH: lane k at bits [k*WIDTH +: WIDTH].
- `out_valid` output N_OUT: one-hot (zero-or-one-hot) per-lane valid.
- `out_ready` input N_OUT: per-lane consumer ready.
- `err_drop` output 1: one-cycle pulse when an out-of-range select is discarded.

## Operation
- One holding register stores `hold_data`, `hold_sel` and `full`. There are two states:
  - EMPTY (`full`=0)
  - FULL (`full`=1)
- Accept condition: `in_valid && in_ready`.
- `in_ready` = `!full || out_ready[hold_sel]`. This allows a same-cycle drain plus refill, so throughput is 1 byte/cycle when the consumer is always ready.
- EMPTY + accept with valid select: go to FULL and latch data/select.
- FULL + drain (`out_ready[hold_sel]`) with no accept: go to EMPTY.
- FULL + drain + accept: stay FULL with the new contents.
- FULL with no drain: hold contents unchanged; `in_ready`=0.
- `out_valid[k]` = `full && hold_sel==k`.
- `out_data` lane `hold_sel` carries `hold_data`. All other lanes drive 0, never stale data.
- Select ≥ `N_OUT` (only possible when N_OUT is not a power of two):
  - the offer is accepted, nothing is stored, and `err_drop` pulses the next cycle;
  - if the block was FULL and draining in that cycle, it goes to EMPTY.
- No reordering: the block holds at most one byte. Delivery order equals acceptance order.

## Timing
- Reset values: `full`=0, `hold_data`=0, `hold_sel`=0, `out_valid`=0, `out_data`=0, `err_drop`=0.
- `in_ready`=1 during the first cycle after reset deasserts.
- Latency: a byte accepted at edge t is visible on `out_valid`/`out_data` after edge t, and is consumed at the first edge with `out_ready[sel]`=1.
- `in_ready` depends combinationally on `out_ready`. No other input→output combinational path exists.
- Reset asserted mid-transfer: the held byte is discarded and nothing is delivered. `rst` has priority over every handshake in the same cycle.
- `out_valid` never drops and `out_data` never changes while the lane is not ready (AXI-style stability).

## Configuration
- `DEMUX8_ROUTE_BROADCAST_EN` defined:
  - adds input `in_bcast` (1 bit);
  - an accepted offer with `in_bcast`=1 loads a pending mask of all ones; `out_valid` = pending mask, and every lane carries `hold_data`;
  - each lane clears its mask bit when its ready is seen; the block leaves FULL when the mask is zero;
  - `in_ready` = `!full || (pending & ~out_ready)==0`;
  - `in_sel` is ignored when `in_bcast`=1.
- Not defined: the port is absent, the pending mask reduces to the one-hot decode of `hold_sel`, and behaviour is exactly as in Operation.

## Structure
- Shared package `cpu_pkg` holds:
  - the `DATA_W` = 8 constant;
  - the `route_state_t` enum {ST_EMPTY, ST_FULL}.
- Sub-module `demux2`: a 1-bit, 1-to-2 combinational steer (d, sel → y0, y1). It is generated per bit and per lane-pair tree level.
- All state stays in the top module.

## Test plan
- Reset, then offer 0xA5 with sel=1 and `out_ready`=2'b11 → `out_valid`=2'b10 with lane1=0xA5 and lane0=0x00 one cycle later; next cycle `out_valid`=0.
- Back-to-back 0x01, 0x02, 0x03 to sel 0,1,0 with readies high → one delivery per cycle, in order; `in_ready` stays 1.
- Offer 0x3C to sel=0 with `out_ready[0]`=0 for 4 cycles → lane0 holds 0x3C stable and `in_ready`=0; on the release cycle a new 0x7E is accepted in the same cycle.
- N_OUT=3, offer sel=3 → `in_ready`=1, `err_drop` pulses once, all `out_valid`=0.
- Assert `rst` while FULL with 0x55 stalled → next cycle `out_valid`=0, `out_data`=0, `in_ready`=1; 0x55 is never delivered.
- With `DEMUX8_ROUTE_BROADCAST_EN`: broadcast 0x99, lane0 ready at cycle 1 and lane1 ready at cycle 3 → `out_valid` goes 2'b11 → 2'b10 → EMPTY after cycle 3; `in_ready` is 0 until the last lane accepts.
